// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (restoring) unit for the MULTDIV slot.
// A start pulse in any state restarts the unit; results are registered on entry to DONE.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH / 2);
  localparam logic [CW-1:0] DIV_LAST  = CW'(WIDTH);

  state_t             state;
  logic [CW-1:0]      step;
  logic [WIDTH+1:0]   acc;      // Booth high accumulator / division remainder
  logic [WIDTH-1:0]   lo;       // multiplier-product low half / quotient
  logic [WIDTH-1:0]   opb;      // multiplicand / divisor magnitude
  logic               q_1;
  logic               neg_q;
  logic               div_zero;
  logic               div_ovf;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH+1:0]   m_ext;
  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   booth_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_fit;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     prod_hi;
  logic               mult_ovf;
  logic [WIDTH-1:0]   quo_signed;

  // Datapath: operand magnitudes, one Booth step, one restoring-division step, final fix-ups
  always_comb begin
    a_mag = data_operandA[WIDTH-1] ? (~data_operandA + {{(WIDTH-1){1'b0}}, 1'b1}) : data_operandA;
    b_mag = data_operandB[WIDTH-1] ? (~data_operandB + {{(WIDTH-1){1'b0}}, 1'b1}) : data_operandB;
    m_ext = {{2{opb[WIDTH-1]}}, opb};
    case ({lo[1:0], q_1})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = ~(m_ext << 1) + {{(WIDTH+1){1'b0}}, 1'b1};
      3'b101, 3'b110: pp = ~m_ext + {{(WIDTH+1){1'b0}}, 1'b1};
      default:        pp = {(WIDTH+2){1'b0}};
    endcase
    booth_sum  = acc + pp;
    div_sh     = {acc[WIDTH-1:0], lo[WIDTH-1]};
    div_fit    = (div_sh >= {1'b0, opb});
    div_rem    = div_fit ? (div_sh - {1'b0, opb}) : div_sh;
    // Product fits signed WIDTH only if bits [2W-1:W-1] are all equal
    prod_hi    = {acc[WIDTH-1:0], lo[WIDTH-1]};
    mult_ovf   = !((&prod_hi) || (~|prod_hi));
    quo_signed = neg_q ? (~lo + {{(WIDTH-1){1'b0}}, 1'b1}) : lo;
  end

  // Control FSM, iteration state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      step           <= {CW{1'b0}};
      acc            <= {(WIDTH+2){1'b0}};
      lo             <= {WIDTH{1'b0}};
      opb            <= {WIDTH{1'b0}};
      q_1            <= 1'b0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= {WIDTH{1'b0}};
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      step           <= {CW{1'b0}};
      acc            <= {(WIDTH+2){1'b0}};
      q_1            <= 1'b0;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MULT;
        lo    <= data_operandB;
        opb   <= data_operandA;
      end else begin
        state    <= DIV;
        lo       <= a_mag;
        opb      <= b_mag;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == {WIDTH{1'b0}});
        div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (data_operandB == {WIDTH{1'b1}});
      end
    end else begin
      case (state)
        MULT: begin
          if (step == MULT_LAST) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= lo;
            data_exception <= mult_ovf;
          end else begin
            acc  <= {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
            lo   <= {booth_sum[1:0], lo[WIDTH-1:2]};
            q_1  <= lo[1];
            step <= step + CW'(1);
          end
        end
        DIV: begin
          if (step == DIV_LAST) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= div_zero ? {WIDTH{1'b0}} : quo_signed;
            data_exception <= div_zero | div_ovf;
          end else begin
            acc  <= {1'b0, div_rem};
            lo   <= {lo[WIDTH-2:0], div_fit};
            step <= step + CW'(1);
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule
